vga_sync_monitor: RTL

Sink-side checker for the VGA raster produced by our timing generator. It samples `hsync`, `vsync` and `blankN` on each pixel-clock enable, measures line and frame lengths, and locks onto the stream after consecutive good frames. While locked it recovers active-area pixel coordinates, so downstream capture and overlay logic, and the verification benches, can index pixels without their own counters.

---
 rtl/vga_sync_monitor.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// VGA raster checker: measures line/frame timing from sampled syncs, locks after
// consecutive good frames, and recovers active-area pixel coordinates while locked.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        pixEn,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blankN,
  output logic        locked,
  output logic        pixValid,
  output logic [9:0]  pixX,
  output logic [9:0]  pixY,
  output logic        frameStart,
  output logic        lineErr,
  output logic        frameErr,
  output logic        syncLost,
  output logic [10:0] lineLen,
  output logic [10:0] frameLines,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;

  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [10:0] TIMEOUT = 11'(2 * H_TOTAL - 1);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic [2:0]  good_cnt_q, good_cnt_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, bl_prev_q, bl_prev_d;
  logic [10:0] pix_cnt_q, pix_cnt_d, ln_cnt_q, ln_cnt_d;
  logic        line_seen_q, line_seen_d, frame_bad_q, frame_bad_d;
  logic [9:0]  x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        locked_q, locked_d, pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        line_err_q, line_err_d, frame_err_q, frame_err_d, sync_lost_q, sync_lost_d;

  logic        hs_edge, vs_edge, bl_rise, bl_fall, timeout, line_err_w, frame_err_w, frame_good;
  logic [10:0] line_len_new, ln_inc;
  logic [9:0]  pix_x_n;
  logic [2:0]  good_inc;

  always_comb begin
    hs_edge      = pixEn & hs_prev_q & ~hsync;
    vs_edge      = pixEn & vs_prev_q & ~vsync;
    bl_rise      = pixEn & ~bl_prev_q & blankN;
    bl_fall      = pixEn & bl_prev_q & ~blankN;
    timeout      = pixEn & ~hs_edge & (pix_cnt_q == TIMEOUT);
    line_len_new = pix_cnt_q + 11'd1;
    line_err_w   = hs_edge & line_seen_q & (line_len_new != H_LEN);
    // A coincident hsync edge is counted before the frame total is captured.
    ln_inc       = (hs_edge && ln_cnt_q != 11'h7FF) ? ln_cnt_q + 11'd1 : ln_cnt_q;
    frame_err_w  = vs_edge & (state_q != SEARCH) & (ln_inc != V_LEN);
    frame_good   = ~frame_bad_q & ~line_err_w & ~frame_err_w;
    good_inc     = good_cnt_q + 3'd1;
    pix_x_n      = 10'd0;

    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    bl_prev_d     = bl_prev_q;
    pix_cnt_d     = pix_cnt_q;
    ln_cnt_d      = ln_cnt_q;
    line_seen_d   = line_seen_q;
    frame_bad_d   = frame_bad_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    sync_lost_d   = 1'b0;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;

    if (pixEn) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      bl_prev_d = blankN;

      if (hs_edge || timeout) pix_cnt_d = 11'd0;
      else if (pix_cnt_q != 11'h7FF) pix_cnt_d = pix_cnt_q + 11'd1;

      if (hs_edge) begin
        line_seen_d = 1'b1;
        if (line_seen_q) line_len_d = line_len_new;
      end

      ln_cnt_d = ln_inc;
      if (vs_edge) begin
        frame_start_d = 1'b1;
        frame_lines_d = ln_inc;
        ln_cnt_d      = 11'd0;
      end

      line_err_d  = line_err_w;
      frame_err_d = frame_err_w;
      sync_lost_d = timeout;

      if (vs_edge) frame_bad_d = 1'b0;
      else if (line_err_w) frame_bad_d = 1'b1;

      if (bl_rise) x_cnt_d = 10'd0;
      if (bl_fall && y_cnt_q != 10'h3FF) y_cnt_d = y_cnt_q + 10'd1;
      if (vs_edge) y_cnt_d = 10'd0;

      if (blankN && state_q == LOCKED) begin
        pix_x_n     = bl_prev_q ? x_cnt_q : 10'd0;
        pix_valid_d = 1'b1;
        pix_x_d     = pix_x_n;
        pix_y_d     = y_cnt_q;
        x_cnt_d     = (pix_x_n == 10'h3FF) ? pix_x_n : pix_x_n + 10'd1;
      end

      unique case (state_q)
        SEARCH: if (vs_edge) begin
          state_d    = MEASURE;
          good_cnt_d = 3'd0;
        end
        MEASURE: if (vs_edge) begin
          if (frame_good) begin
            good_cnt_d = good_inc;
            if (good_inc == LOCK_N) state_d = LOCKED;
          end else begin
            good_cnt_d = 3'd0;
          end
        end
        LOCKED: if (line_err_w || frame_err_w) state_d = SEARCH;
        default: state_d = SEARCH;
      endcase

      if (timeout) begin
        state_d     = SEARCH;
        line_seen_d = 1'b0;
      end
      // Line measurement restarts from scratch whenever the stream is dropped.
      if (state_d == SEARCH && state_q != SEARCH) line_seen_d = 1'b0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= SEARCH;
      good_cnt_q    <= 3'd0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      bl_prev_q     <= 1'b0;
      pix_cnt_q     <= 11'd0;
      ln_cnt_q      <= 11'd0;
      line_seen_q   <= 1'b0;
      frame_bad_q   <= 1'b0;
      x_cnt_q       <= 10'd0;
      y_cnt_q       <= 10'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 11'd0;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      bl_prev_q     <= bl_prev_d;
      pix_cnt_q     <= pix_cnt_d;
      ln_cnt_q      <= ln_cnt_d;
      line_seen_q   <= line_seen_d;
      frame_bad_q   <= frame_bad_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      locked_q      <= locked_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      sync_lost_q   <= sync_lost_d;
    end
  end

  assign locked     = locked_q;
  assign pixValid   = pix_valid_q;
  assign pixX       = pix_x_q;
  assign pixY       = pix_y_q;
  assign frameStart = frame_start_q;
  assign lineErr    = line_err_q;
  assign frameErr   = frame_err_q;
  assign syncLost   = sync_lost_q;
  assign lineLen    = line_len_q;
  assign frameLines = frame_lines_q;
  assign dbgState   = state_q;

endmodule
